// File: rtl/pll_lock_detector.sv
// pll_lock_detector: qualifies PLL lock from tuning-word stability sampled on synchronised reference ticks.
module pll_lock_detector #(
    parameter int TW_WIDTH      = 32,
    parameter int TOL           = 2000,
    parameter int LOCK_CYCLES   = 64,
    parameter int UNLOCK_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                ref_clk,
    input  logic [TW_WIDTH-1:0] tuning_word,
    output logic                locked,
    output logic                lock_lost,
    output logic                ref_tick,
    output logic [15:0]         stable_count,
    output logic [TW_WIDTH-1:0] last_delta
);
    typedef enum logic [1:0] {IDLE, PRIME, SEEK, LOCKED} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic hist_q, hist_d, tick_q, tick_d;
    logic locked_q, locked_d, lock_lost_q, lock_lost_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0] bad_q, bad_d;
    logic [TW_WIDTH-1:0] prev_q, prev_d, last_q, last_d, delta;
    logic [TW_WIDTH:0] diff;
    logic good, cnt_hit, bad_hit, upd;
    always_ff @(posedge sys_clk) begin
        state_q <= rst ? IDLE : state_d;
    end
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync_q      <= '0;
            hist_q      <= 1'b0;
            tick_q      <= 1'b0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            cnt_q       <= '0;
            bad_q       <= '0;
            prev_q      <= '0;
            last_q      <= '0;
        end else begin
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            tick_q      <= tick_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            prev_q      <= prev_d;
            last_q      <= last_d;
        end
    end
    // Edge detect and absolute delta without modular wrap
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], ref_clk};
        hist_d  = sync_q[SYNC_STAGES-1];
        tick_d  = sync_q[SYNC_STAGES-1] & ~hist_q;
        diff    = {1'b0, tuning_word} - {1'b0, prev_q};
        delta   = diff[TW_WIDTH] ? TW_WIDTH'(-diff) : diff[TW_WIDTH-1:0];
        good    = delta <= TW_WIDTH'(TOL);
        cnt_hit = cnt_q + 16'd1 == 16'(LOCK_CYCLES);
        bad_hit = bad_q + 8'd1 == 8'(UNLOCK_CYCLES);
    end
    always_comb begin
        state_d = !enable                                 ? IDLE   :
                  state_q == IDLE                         ? PRIME  :
                  !tick_q                                 ? state_q :
                  state_q == PRIME                        ? SEEK   :
                  state_q == SEEK && good && cnt_hit      ? LOCKED :
                  state_q == LOCKED && !good && bad_hit   ? SEEK   : state_q;
    end
    always_comb begin
        upd         = enable && tick_q && state_q != IDLE;
        locked_d    = state_d == LOCKED;
        lock_lost_d = state_q == LOCKED && state_d == SEEK;
        prev_d      = upd ? tuning_word : prev_q;
        last_d      = upd ? delta : last_q;
        cnt_d       = !enable || state_q == IDLE || lock_lost_d || (upd && state_q == SEEK && !good) ? '0 :
                      upd && state_q != PRIME && good && !(&cnt_q) ? cnt_q + 16'd1 : cnt_q;
        bad_d       = !enable || state_q != LOCKED || lock_lost_d ? '0 :
                      upd ? (good ? '0 : bad_q + 8'd1) : bad_q;
    end
    assign locked       = locked_q;
    assign lock_lost    = lock_lost_q;
    assign ref_tick     = tick_q;
    assign stable_count = cnt_q;
    assign last_delta   = last_q;
endmodule

// File: doc/pll_lock_detector.md
Name: pll_lock_detector

Overview:
- Digital lock detector that sits directly downstream of pll_top.
- Consumes the DCO tuning word (debug_tuning_word) and the raw reference clock.
- Samples the tuning word on every reference rising edge.
- Declares lock once the word has stayed stable for a programmable number of consecutive reference cycles, with hysteresis on unlock.
- Replaces the free-running locked_debug flag as the qualified lock indication for downstream logic.

Parameters:
- TW_WIDTH, 32: width of the tuning word.
- TOL, 2000: maximum absolute tick-to-tick tuning-word change that still counts as stable (inclusive).
- LOCK_CYCLES, 64: consecutive stable reference ticks required to enter lock (1..65535).
- UNLOCK_CYCLES, 4: consecutive unstable reference ticks required to drop lock (1..255).
- SYNC_STAGES, 2: synchroniser depth for ref_clk into the sys_clk domain (>=2).

Ports:
- sys_clk, input, 1: single block clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: detector enable; low forces IDLE.
- ref_clk, input, 1: raw reference clock, asynchronous to sys_clk.
- tuning_word, input, TW_WIDTH: DCO tuning word from pll_top; static between reference ticks.
- locked, output, 1: qualified lock flag.
- lock_lost, output, 1: one-cycle pulse on the LOCKED->SEEK transition.
- ref_tick, output, 1: one-cycle pulse per synchronised ref_clk rising edge.
- stable_count, output, 16: current consecutive-stable tick count (saturating).
- last_delta, output, TW_WIDTH: absolute difference computed at the most recent tick.

Behaviour:
- Reset (rst=1 at a sys_clk edge):
  - Outputs: locked=0, lock_lost=0, ref_tick=0, stable_count=0, last_delta=0.
  - Internals: prev_tw=0, bad_count=0, synchroniser flops=0.
  - State: IDLE.
  - Reset has priority over every other event, including mid-LOCKED. Locked drops the cycle after rst is sampled, with no lock_lost pulse.
- Synchroniser:
  - ref_clk passes through SYNC_STAGES flops plus one history flop.
  - ref_tick = sync_out & ~history, registered.
  - Latency: ref_clk rising edge to ref_tick high = SYNC_STAGES+1 sys_clk cycles (3 at default). ref_tick is exactly one cycle wide.
  - ref_tick runs in every state, including IDLE.
- Delta:
  - On a tick: delta = |tuning_word - prev_tw|, computed in TW_WIDTH+1 bits and truncated to TW_WIDTH. There is no modular wrap, so 0xFFFFFFFF->0x00000000 gives delta 0xFFFFFFFF.
  - good = (delta <= TOL).
  - last_delta and prev_tw update on every tick in PRIME, SEEK and LOCKED.
- State machine (advances only on a ref_tick cycle unless noted):
  - IDLE: enable=1 -> PRIME (next cycle, no tick needed).
  - PRIME: first tick captures prev_tw only; stable_count stays 0; -> SEEK.
  - SEEK: good tick -> stable_count+1; when the incremented value equals LOCK_CYCLES -> LOCKED with locked=1 the same cycle the state updates. Bad tick -> stable_count=0, stay SEEK.
  - LOCKED: good tick -> bad_count=0, stable_count saturates at 0xFFFF. Bad tick -> bad_count+1; when the incremented value equals UNLOCK_CYCLES -> SEEK, locked=0, lock_lost=1 for one cycle, stable_count=0, bad_count=0.
  - Any state: enable=0 -> IDLE next cycle. Locked=0 and stable_count=0, with no lock_lost pulse; prev_tw is retained but re-primed on re-entry.
- Simultaneous enable falling and tick: enable wins and the tick is ignored for state purposes (ref_tick still pulses).
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Hold tuning_word=343597383, ref 100 ns / sys 2 ns, enable=1 -> ref_tick every 50 cycles; locked rises on the 65th tick (1 prime + 64 good); stable_count=64; last_delta=0.
- Ramp tuning_word +5000 per tick from 85899345 -> locked stays 0; stable_count stays 0; last_delta=5000 each tick.
- Steps of exactly TOL (2000) then 2001 -> 2000 counts as good (count increments); 2001 resets stable_count to 0.
- While locked: one bad tick (+10000) then good ticks -> locked stays 1 and bad_count clears; four consecutive bad ticks -> lock_lost pulses for 1 cycle on the 4th, then locked=0, stable_count=0.
- Tuning word wraps 0xFFFFFFFF->0x00000000 while in SEEK -> last_delta=0xFFFFFFFF; stable_count resets to 0.
- Assert rst for 1 cycle while locked, and separately drop enable while locked -> in both cases locked=0 next cycle with no lock_lost pulse; after re-enable, lock requires a fresh prime plus 64 good ticks.
